// File: rtl/portgroup_tx_pkg.sv
// Shared types and helpers for the portgroup TX sequencer.
//   tx_state_e    : sequencer states (IDLE / SEND / GAP)
//   gap_cnt_width : gap-counter width needed for a given gap length (>= 1 bit)
package portgroup_tx_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } tx_state_e;

  // The counter only has to reach gap-1, so $clog2(gap) bits, never fewer than one.
  function automatic int unsigned gap_cnt_width(input int unsigned gap);
    return (gap > 1) ? $clog2(gap) : 1;
  endfunction

  localparam int unsigned gap_default_lp     = 2;
  localparam int unsigned gap_cnt_width_dflt = gap_cnt_width(gap_default_lp);

endpackage

// File: rtl/portgroup_tx_hold.sv
// One-entry pending buffer for register-file TX data writes.
//   clk, rst_n       : clock, async active-low reset
//   upd, data        : write strobe and word from the register file
//   drain            : sequencer takes the pending word this cycle
//   clr              : clear the sticky overflow flag
//   pend_valid/data  : buffered word
//   ovf              : sticky, set when an update found the buffer full
module portgroup_tx_hold
  import portgroup_tx_pkg::*;
#(
  parameter int unsigned width_p = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               upd,
  input  logic [width_p-1:0] data,
  input  logic               drain,
  input  logic               clr,
  output logic               pend_valid,
  output logic [width_p-1:0] pend_data,
  output logic               ovf
);

  logic capture;
  logic drop;

  // A draining buffer counts as free, so a write in the drain cycle is kept.
  always_comb begin
    capture = upd & (~pend_valid | drain);
    drop    = upd & pend_valid & ~drain;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pend_valid <= 1'b0;
      pend_data  <= '0;
      ovf        <= 1'b0;
    end else begin
      if (capture) begin
        pend_valid <= 1'b1;
        pend_data  <= data;
      end else if (drain) begin
        pend_valid <= 1'b0;
      end
      // A fresh overflow beats a simultaneous clear.
      if (drop) begin
        ovf <= 1'b1;
      end else if (clr) begin
        ovf <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/portgroup_tx_ctrl.sv
// Transmit sequencer: buffers one register-file word and sends it on a
// valid/ready stream, followed by gap_p idle cycles.
//   main_clk_i, main_rst_an_i : clock, async active-low reset
//   regf_*                    : enable, data word, write strobe, status clear
//   tx_valid_o/ready_i/data_o : output stream
//   busy_o, done_o, ovf_o, cnt_o : status back to the register file
module portgroup_tx_ctrl
  import portgroup_tx_pkg::*;
#(
  parameter int unsigned width_p     = 8,
  parameter int unsigned gap_p       = 2,
  parameter int unsigned cnt_width_p = 16
) (
  input  logic                   main_clk_i,
  input  logic                   main_rst_an_i,
  input  logic                   regf_ctrl_ena_rval_i,
  input  logic [width_p-1:0]     regf_tx_data0_rval_i,
  input  logic                   regf_tx_data0_upd_i,
  input  logic                   regf_stat_clr_i,
  output logic                   tx_valid_o,
  input  logic                   tx_ready_i,
  output logic [width_p-1:0]     tx_data_o,
  output logic                   busy_o,
  output logic                   done_o,
  output logic                   ovf_o,
  output logic [cnt_width_p-1:0] cnt_o
);

  localparam int unsigned gap_w_lp    = gap_cnt_width(gap_p);
  localparam int unsigned gap_last_lp = (gap_p > 0) ? gap_p - 1 : 0;

  tx_state_e             state_q, state_n;
  logic [gap_w_lp-1:0]   gap_cnt_q, gap_cnt_n;
  logic                  valid_n;
  logic [width_p-1:0]    data_n;
  logic                  done_n;
  logic [cnt_width_p-1:0] cnt_n;
  logic                  drain;
  logic                  handshake;
  logic                  pend_valid;
  logic [width_p-1:0]    pend_data;

  portgroup_tx_hold #(
    .width_p (width_p)
  ) u_hold (
    .clk        (main_clk_i),
    .rst_n      (main_rst_an_i),
    .upd        (regf_tx_data0_upd_i),
    .data       (regf_tx_data0_rval_i),
    .drain      (drain),
    .clr        (regf_stat_clr_i),
    .pend_valid (pend_valid),
    .pend_data  (pend_data),
    .ovf        (ovf_o)
  );

  // Next-state and next-output logic.
  always_comb begin
    state_n   = state_q;
    gap_cnt_n = gap_cnt_q;
    valid_n   = tx_valid_o;
    data_n    = tx_data_o;
    done_n    = 1'b0;
    drain     = 1'b0;
    handshake = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (regf_ctrl_ena_rval_i && pend_valid) begin
          state_n = ST_SEND;
          valid_n = 1'b1;
          data_n  = pend_data;
          drain   = 1'b1;
        end
      end
      ST_SEND: begin
        if (tx_ready_i) begin
          handshake = 1'b1;
          done_n    = 1'b1;
          valid_n   = 1'b0;
          if (gap_p > 0) begin
            state_n   = ST_GAP;
            gap_cnt_n = '0;
          end else if (regf_ctrl_ena_rval_i && pend_valid) begin
            // Zero gap: chain the next word without an IDLE bubble.
            state_n = ST_SEND;
            valid_n = 1'b1;
            data_n  = pend_data;
            drain   = 1'b1;
          end else begin
            state_n = ST_IDLE;
          end
        end
      end
      ST_GAP: begin
        if (gap_cnt_q == gap_w_lp'(gap_last_lp)) begin
          state_n   = ST_IDLE;
          gap_cnt_n = '0;
        end else begin
          gap_cnt_n = gap_cnt_q + gap_w_lp'(1);
        end
      end
      default: begin
        state_n = ST_IDLE;
        valid_n = 1'b0;
      end
    endcase

    // Clear beats a same-cycle increment.
    if (regf_stat_clr_i) begin
      cnt_n = '0;
    end else if (handshake) begin
      cnt_n = cnt_o + cnt_width_p'(1);
    end else begin
      cnt_n = cnt_o;
    end
  end

  // State and registered outputs.
  always_ff @(posedge main_clk_i or negedge main_rst_an_i) begin
    if (!main_rst_an_i) begin
      state_q    <= ST_IDLE;
      gap_cnt_q  <= '0;
      tx_valid_o <= 1'b0;
      tx_data_o  <= '0;
      busy_o     <= 1'b0;
      done_o     <= 1'b0;
      cnt_o      <= '0;
    end else begin
      state_q    <= state_n;
      gap_cnt_q  <= gap_cnt_n;
      tx_valid_o <= valid_n;
      tx_data_o  <= data_n;
      busy_o     <= (state_n != ST_IDLE);
      done_o     <= done_n;
      cnt_o      <= cnt_n;
    end
  end

endmodule

// File: doc/portgroup_tx_ctrl.md
Name: portgroup_tx_ctrl

Overview:
Transmit sequencer for the portgroup TX datapath. It takes the register-file values for enable and TX data word, plus a write-update strobe, and buffers one pending word. It drives words out on a valid/ready stream with a configurable inter-word gap. It reports busy, done, overflow and a transfer count back to the register file.

Parameters:
width_p, 8, TX data word width in bits.
gap_p, 2, idle cycles inserted after each accepted transfer (0 allowed).
cnt_width_p, 16, width of the transfer counter.

Ports:
main_clk_i  input  1  clock
main_rst_an_i  input  1  async reset, active-low
regf_ctrl_ena_rval_i  input  1  TX enable (core read value)
regf_tx_data0_rval_i  input  width_p  TX data word (core read value)
regf_tx_data0_upd_i  input  1  one-cycle pulse: bus wrote tx_data0
regf_stat_clr_i  input  1  one-cycle pulse: clear overflow flag and counter
tx_valid_o  output  1  stream valid
tx_ready_i  input  1  stream ready
tx_data_o  output  width_p  stream data
busy_o  output  1  state != IDLE
done_o  output  1  one-cycle pulse per completed handshake
ovf_o  output  1  sticky: update dropped because the pending buffer was full
cnt_o  output  cnt_width_p  completed-transfer count

Behaviour:
- Clock: main_clk_i only. Reset: main_rst_an_i, asynchronous assert, active-low.
- Reset values: tx_valid_o=0, tx_data_o=0, busy_o=0, done_o=0, ovf_o=0, cnt_o=0. Pending buffer empty, state IDLE, gap counter 0.
- Pending buffer (1 entry):
  - Upd pulse with buffer empty, or buffer being drained in the same cycle: capture regf_tx_data0_rval_i, pend_valid=1.
  - Upd pulse with buffer full and not draining: data dropped, pend_valid unchanged, ovf_o=1 next cycle.
- FSM states IDLE, SEND, GAP:
  - IDLE: if ena & pend_valid, then next cycle SEND, tx_data_o<=pend data, tx_valid_o=1, pend drained.
  - SEND: tx_valid_o=1 and tx_data_o stable until tx_ready_i=1.
    - On handshake: done_o=1 next cycle, cnt_o+1 (wraps to 0 after all-ones).
    - Next state is GAP if gap_p>0, else IDLE.
    - With gap_p=0, ena=1 and pend_valid=1 at handshake: SEND directly, pend drained, back-to-back words.
  - GAP: counts gap_p cycles with tx_valid_o=0, then IDLE.
- Latency: upd sampled at edge N, pend_valid during N+1, tx_valid_o high from N+2 (ena=1, IDLE, ready held high).
- ena deasserted in SEND: the current word is not withdrawn; the handshake completes, then the FSM parks in IDLE and the pending word is held.
- ena deasserted in GAP: gap finishes, then IDLE.
- regf_stat_clr_i: ovf_o=0, cnt_o=0 next cycle.
  - Same-cycle handshake increment: clear wins, cnt_o=0.
  - Same-cycle new overflow: overflow wins, ovf_o=1.
- tx_valid_o, busy_o, done_o, cnt_o and ovf_o are registered outputs; no combinational input-to-output paths.
- Reset mid-SEND: tx_valid_o drops immediately (async); the pending word is lost.

Decomposition:
- Package portgroup_tx_pkg holds the state enum (IDLE/SEND/GAP) and a gap-counter width constant computed from gap_p (minimum 1 bit).
- One natural sub-module: portgroup_tx_hold, the 1-entry pending buffer with capture/drain/overflow logic. The FSM, gap counter and transfer counter stay in the top.

Test Plan:
- Reset release, ena=1, upd with data 0xA5, ready=1: tx_valid_o high 2 cycles after upd with data 0xA5; done_o pulses; cnt_o=1; busy_o high through SEND plus 2 GAP cycles.
- ready=0 for 5 cycles during SEND: tx_valid_o and tx_data_o stay stable at 0x3C; done_o only after ready=1; exactly one count increment.
- Three upd pulses (0x01, 0x02, 0x03) on consecutive cycles while ena=0: 0x01 held, ovf_o=1. ena=1 then produces only 0x01; after stat_clr, ovf_o=0 and cnt_o=0.
- gap_p=0, ready=1: upd every cycle with 0x10, 0x11, 0x12 gives back-to-back tx_valid_o=1 with those data, cnt_o=3, ovf_o=0.
- ena dropped mid-SEND while a second word is pending: first word completes on ready; second word not sent until ena=1 again.
- Counter preloaded to 0xFFFF via 65535 transfers (or forced): next transfer gives cnt_o=0x0000. stat_clr coincident with a handshake gives cnt_o=0.
